// File: rtl/sfm_acc_inv_buffer.sv
// ---------------------------------------------------------------------------
// sfm_acc_inv_buffer
//
// Reciprocal hold-and-replay buffer placed right after the accumulator's
// denominator inverter. Each reciprocal produced at the end of a row is
// captured together with that row's element count. It is then replayed once
// per element to the normalisation multiplier. The final replay carries a
// last-use flag, and after it the entry is retired. This lets the next row's
// reduction run while the current row is still being normalised.
//
// Parameters:
//   WIDTH      width of the reciprocal in bits (the bit width of the
//              reciprocal's floating-point format, e.g. 32 for FP32)
//   DEPTH      number of stored reciprocals (power of two, >= 2)
//   CNT_WIDTH  width of the per-row element count
//
// Ports:
//   clk_i        in   1          clock, all logic on the rising edge
//   rst_i        in   1          synchronous active-high reset
//   clear_i      in   1          synchronous flush, same effect as rst_i
//   inv_valid_i  in   1          reciprocal from inverter is valid
//   inv_ready_o  out  1          buffer can accept a reciprocal
//   inv_i        in   WIDTH      reciprocal value
//   len_i        in   CNT_WIDTH  replay count for the pushed entry
//   inv_valid_o  out  1          head reciprocal available
//   inv_ready_i  in   1          normaliser consumes one replay
//   inv_o        out  WIDTH      head reciprocal ('0 when not valid)
//   last_o       out  1          current replay is the head's final one
//   occupancy_o  out  log2(DEPTH)+1  number of stored entries
//                                    (present only when the configuration
//                                    macro below is defined)
//
// Configuration macro:
//   SFM_INV_BUF_OCCUPANCY_EN  when defined, adds the occupancy_o port
// ---------------------------------------------------------------------------
module sfm_acc_inv_buffer #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         inv_valid_i,
    output logic                         inv_ready_o,
    input  logic [WIDTH-1:0]             inv_i,
    input  logic [CNT_WIDTH-1:0]         len_i,
    output logic                         inv_valid_o,
    input  logic                         inv_ready_i,
    output logic [WIDTH-1:0]             inv_o,
`ifdef SFM_INV_BUF_OCCUPANCY_EN
    output logic                         last_o,
    output logic [$clog2(DEPTH):0]       occupancy_o
`else
    output logic                         last_o
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // DEPTH expressed in the occupancy counter's width, for the full check.
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    // Storage: one reciprocal and its replay length per slot.
    logic [WIDTH-1:0]     inv_mem [DEPTH];
    logic [CNT_WIDTH-1:0] len_mem [DEPTH];

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       count;
    logic [CNT_WIDTH-1:0] use_cnt;

    logic                 flush;
    logic                 push;
    logic                 pop;
    logic                 retire;
    logic [CNT_WIDTH-1:0] head_len;
    logic [CNT_WIDTH-1:0] len_store;

    // Handshake qualifiers and head-of-queue decode. The ready output looks
    // only at the stored count, so a same-cycle pop never opens a slot early.
    // It is also forced low during reset or clear, because those cycles
    // discard any push.
    always_comb begin
        flush       = rst_i | clear_i;
        inv_ready_o = (count < DEPTH_CNT) & ~flush;
        push        = inv_valid_i & inv_ready_o;

        inv_valid_o = (count != '0);
        head_len    = len_mem[rd_ptr];
        inv_o       = inv_valid_o ? inv_mem[rd_ptr] : '0;

        // Stored lengths are never zero, so head_len - 1 cannot wrap.
        last_o      = inv_valid_o & (use_cnt == (head_len - CNT_WIDTH'(1)));

        pop         = inv_valid_o & inv_ready_i;
        retire      = pop & last_o;

        // A zero-length row still needs its reciprocal used once.
        len_store   = (len_i == '0) ? CNT_WIDTH'(1) : len_i;
    end

    // The storage array is written on push only and is never reset. Slots
    // become meaningful only once the occupancy count says so.
    always_ff @(posedge clk_i) begin
        if (push) begin
            inv_mem[wr_ptr] <= inv_i;
            len_mem[wr_ptr] <= len_store;
        end
    end

    // Pointers, occupancy and the replay counter. A flush has priority over
    // any same-cycle push or pop and abandons a partially replayed row. A
    // simultaneous push and retire leaves the count unchanged while both
    // pointers move. The pointers wrap naturally because DEPTH is a power
    // of two.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            use_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            if (pop) begin
                if (last_o) begin
                    use_cnt <= '0;
                    rd_ptr  <= rd_ptr + PTR_W'(1);
                end else begin
                    use_cnt <= use_cnt + CNT_WIDTH'(1);
                end
            end

            case ({push, retire})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef SFM_INV_BUF_OCCUPANCY_EN
    // The occupancy output is just the internal count. Because the count is
    // a register, it follows pushes and retires one cycle later.
    assign occupancy_o = count;
`endif

endmodule

// File: tb/tb_sfm_acc_inv_buffer.sv
// ---------------------------------------------------------------------------
// tb_sfm_acc_inv_buffer
//
// Self-checking bench for sfm_acc_inv_buffer. The reference model is a queue
// of {reciprocal, replay length} records plus a count of replays already
// used on the head record. Each step, the model's expected outputs are
// compared with the DUT's outputs.
// ---------------------------------------------------------------------------
module tb_sfm_acc_inv_buffer;

    localparam int WIDTH     = 32;
    localparam int DEPTH     = 4;
    localparam int CNT_WIDTH = 16;

    logic                 clk_i;
    logic                 rst_i;
    logic                 clear_i;
    logic                 inv_valid_i;
    logic                 inv_ready_o;
    logic [WIDTH-1:0]     inv_i;
    logic [CNT_WIDTH-1:0] len_i;
    logic                 inv_valid_o;
    logic                 inv_ready_i;
    logic [WIDTH-1:0]     inv_o;
    logic                 last_o;
`ifdef SFM_INV_BUF_OCCUPANCY_EN
    logic [$clog2(DEPTH):0] occupancy_o;
`endif

    sfm_acc_inv_buffer #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .inv_valid_i (inv_valid_i),
        .inv_ready_o (inv_ready_o),
        .inv_i       (inv_i),
        .len_i       (len_i),
        .inv_valid_o (inv_valid_o),
        .inv_ready_i (inv_ready_i),
        .inv_o       (inv_o),
`ifdef SFM_INV_BUF_OCCUPANCY_EN
        .last_o      (last_o),
        .occupancy_o (occupancy_o)
`else
        .last_o      (last_o)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        logic [WIDTH-1:0] inv;
        int               len;
    } entry_t;

    entry_t model_q[$];
    int     model_used;
    int     vectors;
    int     miscompares;
    int     handshakes;
    int     len_sum;

    // Compares one observed value against the model's expectation.
    task automatic check_output(input string tag, input logic [WIDTH-1:0] observed,
                                input logic [WIDTH-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, checks the DUT against the model, and then
    // advances the model across the rising edge.
    task automatic apply_stimulus(input logic r, input logic c, input logic v,
                                  input logic [WIDTH-1:0] d, input logic [CNT_WIDTH-1:0] l,
                                  input logic rd);
        logic             exp_valid;
        logic             exp_last;
        logic             exp_ready;
        logic [WIDTH-1:0] exp_inv;
        @(negedge clk_i);
        rst_i       = r;
        clear_i     = c;
        inv_valid_i = v;
        inv_i       = d;
        len_i       = l;
        inv_ready_i = rd;
        #1;
        exp_valid = (model_q.size() != 0);
        exp_inv   = exp_valid ? model_q[0].inv : '0;
        exp_last  = exp_valid && (model_used == model_q[0].len - 1);
        exp_ready = (model_q.size() < DEPTH) && !r && !c;
        check_output("inv_ready_o", WIDTH'(inv_ready_o), WIDTH'(exp_ready));
        check_output("inv_valid_o", WIDTH'(inv_valid_o), WIDTH'(exp_valid));
        check_output("inv_o", inv_o, exp_inv);
        check_output("last_o", WIDTH'(last_o), WIDTH'(exp_last));
`ifdef SFM_INV_BUF_OCCUPANCY_EN
        check_output("occupancy_o", WIDTH'(occupancy_o), WIDTH'(model_q.size()));
`endif
        if (inv_valid_o && rd) handshakes++;
        @(posedge clk_i);
        if (r || c) begin
            model_q.delete();
            model_used = 0;
        end else begin
            if (exp_valid && rd) begin
                if (exp_last) begin
                    void'(model_q.pop_front());
                    model_used = 0;
                end else begin
                    model_used++;
                end
            end
            if (v && exp_ready) model_q.push_back('{d, (l == 0) ? 1 : int'(l)});
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        handshakes  = 0;
        model_used  = 0;
        rst_i       = 1'b1;
        clear_i     = 1'b0;
        inv_valid_i = 1'b0;
        inv_i       = '0;
        len_i       = '0;
        inv_ready_i = 1'b0;

        $display("[TB] reset");
        apply_stimulus(1, 0, 1, 32'h1111_1111, 16'd2, 1);
        apply_stimulus(1, 0, 0, '0, '0, 0);

        $display("[TB] single entry");
        apply_stimulus(0, 0, 1, 32'h3E80_0000, 16'd3, 1);
        for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 0, '0, '0, 1);

        $display("[TB] fill and stall");
        for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 1, 32'hA000_0000 + i, 16'd1, 0);
        apply_stimulus(0, 0, 1, 32'hA000_0004, 16'd1, 1);
        apply_stimulus(0, 0, 1, 32'hA000_0004, 16'd1, 0);
        for (int i = 0; i < 6; i++) apply_stimulus(0, 0, 0, '0, '0, 1);

        $display("[TB] back-to-back rows");
        apply_stimulus(0, 0, 1, 32'hBF80_0000, 16'd2, 1);
        apply_stimulus(0, 0, 1, 32'h4000_0000, 16'd1, 1);
        for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 0, '0, '0, 1);

        $display("[TB] zero length");
        apply_stimulus(0, 0, 1, 32'h8123_4567, 16'd0, 1);
        for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, '0, '0, 1);

        $display("[TB] clear mid-row");
        apply_stimulus(0, 0, 1, 32'h3F00_0000, 16'd5, 1);
        apply_stimulus(0, 0, 0, '0, '0, 1);
        apply_stimulus(0, 0, 0, '0, '0, 1);
        apply_stimulus(0, 1, 1, 32'hDEAD_BEEF, 16'd3, 1);
        apply_stimulus(0, 0, 0, '0, '0, 1);
        apply_stimulus(0, 0, 1, 32'h3C00_0000, 16'd2, 1);
        for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 0, '0, '0, 1);

        $display("[TB] backpressure stability");
        handshakes = 0;
        len_sum    = 0;
        for (int i = 0; i < 3; i++) begin
            logic [CNT_WIDTH-1:0] l;
            l = CNT_WIDTH'($urandom_range(0, 4));
            len_sum += (l == 0) ? 1 : int'(l);
            apply_stimulus(0, 0, 1, $urandom, l, 1'($urandom));
        end
        for (int i = 0; i < 60; i++) apply_stimulus(0, 0, 0, '0, '0, 1'($urandom));
        for (int i = 0; i < 16; i++) apply_stimulus(0, 0, 0, '0, '0, 1);
        check_output("handshake_total", WIDTH'(handshakes), WIDTH'(len_sum));

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(0, ($urandom_range(0, 39) == 0), 1'($urandom),
                           $urandom, CNT_WIDTH'($urandom_range(0, 5)), 1'($urandom));
        end
        apply_stimulus(1, 0, 0, '0, '0, 1);
        apply_stimulus(0, 0, 0, '0, '0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
